// File: rtl/brick_field.sv
// brick_field: ROWS x COLS brick wall for Breakout.
// After each ball tick the grid is scanned one brick per cycle. At most one
// collision (the lowest brick index) is reported, together with the struck face.
// A registered per-pixel brick mask and colour feed the VGA mux.
// 'cleared' flags an empty field.
// Optional feature: define BRICK_FIELD_DURABILITY_EN to give upper rows more lives.
module brick_field #(
    parameter int COLS    = 5,
    parameter int ROWS    = 2,
    parameter int BRICK_W = 128,
    parameter int BRICK_H = 32,
    parameter int X0      = 0,
    parameter int Y0      = 0,
    parameter int GAP     = 2,
    parameter int R_BALL  = 8,
    parameter int LIFE_W  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [9:0]  x_ball,
    input  logic [9:0]  y_ball,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    output logic        area,
    output logic [23:0] rgb,
    output logic        hit_block,
    output logic        hit_block_up,
    output logic        hit_block_down,
    output logic        hit_block_left,
    output logic        hit_block_right,
    output logic [4:0]  hit_id,
    output logic        destroyed,
    output logic        cleared
);

    localparam int          N        = ROWS * COLS;
    localparam int          XS       = $clog2(BRICK_W);
    localparam int          YS       = $clog2(BRICK_H);
    localparam logic [4:0]  LAST_IDX = 5'(N - 1);
    localparam logic [4:0]  COL_LAST = 5'(COLS - 1);
    localparam logic [10:0] X0_C     = 11'(X0);
    localparam logic [10:0] Y0_C     = 11'(Y0);
    localparam logic [10:0] GRID_W   = 11'(COLS * BRICK_W);
    localparam logic [10:0] GRID_H   = 11'(ROWS * BRICK_H);
    localparam logic [10:0] CELL_W   = 11'(BRICK_W);
    localparam logic [10:0] CELL_H   = 11'(BRICK_H);
    localparam logic [10:0] GAP_C    = 11'(GAP);
    localparam logic [10:0] R_OFF_X  = 11'(BRICK_W - 1 - GAP);
    localparam logic [10:0] R_OFF_Y  = 11'(BRICK_H - 1 - GAP);
    localparam logic [10:0] MASK_X   = 11'(BRICK_W - 1);
    localparam logic [10:0] MASK_Y   = 11'(BRICK_H - 1);
    localparam logic [20:0] R2       = 21'(R_BALL * R_BALL);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
    typedef enum logic [1:0] {FACE_UP, FACE_DOWN, FACE_LEFT, FACE_RIGHT} face_t;

    // Starting lives for the whole grid, walked row by row.
    function automatic logic [N*LIFE_W-1:0] init_lives();
        logic [N*LIFE_W-1:0] v;
        int k;
        v = '0;
        k = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
`ifdef BRICK_FIELD_DURABILITY_EN
                if (ROWS - r > (1 << LIFE_W) - 1) v[k*LIFE_W +: LIFE_W] = '1;
                else                              v[k*LIFE_W +: LIFE_W] = LIFE_W'(ROWS - r);
`else
                v[k*LIFE_W +: LIFE_W] = LIFE_W'(1);
`endif
                k++;
            end
        end
        return v;
    endfunction

    localparam logic [N*LIFE_W-1:0] INIT_LIVES = init_lives();

    state_t            state, state_next;
    logic              hold;
    logic [LIFE_W-1:0] life      [N];
    logic [LIFE_W-1:0] life_next [N];
    logic              any_live_next;
    logic [4:0]        idx, hit_idx, col;
    logic [10:0]       cell_x, cell_y;
    logic              hit_valid;
    face_t             hit_face, face_now;
    logic [LIFE_W-1:0] cur_life, hit_life, pix_life;

    logic [10:0] bx, by, brk_l, brk_r, brk_t, brk_b, dx_full, dy_full;
    logic [9:0]  dx, dy;
    logic [19:0] dx_sq, dy_sq;
    logic [20:0] dist2;
    logic        brick_hit;

    logic [10:0] px, py, cx, cy, ox, oy;
    logic [15:0] pix_idx;
    logic        in_grid, in_body, area_d;
    logic [23:0] rgb_d;

    assign hold = reset || !start;

    // State register; reset or start low forces IDLE.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (hold) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: a tick starts a scan; ticks outside IDLE are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = SCAN;
            SCAN:    if (idx == LAST_IDX) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Life lookups for the brick under scan and for the latched hit.
    always_comb begin
        cur_life = '0;
        hit_life = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == 5'(i))     cur_life = life[i];
            if (hit_idx == 5'(i)) hit_life = life[i];
        end
    end

    // Clamped-point distance test and face of the brick under scan.
    always_comb begin
        bx      = {1'b0, x_ball};
        by      = {1'b0, y_ball};
        brk_l   = cell_x + GAP_C;
        brk_r   = cell_x + R_OFF_X;
        brk_t   = cell_y + GAP_C;
        brk_b   = cell_y + R_OFF_Y;
        dx_full = '0;
        dy_full = '0;
        if (bx < brk_l)      dx_full = brk_l - bx;
        else if (bx > brk_r) dx_full = bx - brk_r;
        if (by < brk_t)      dy_full = brk_t - by;
        else if (by > brk_b) dy_full = by - brk_b;
        // Distances beyond 10 bits saturate; they are far outside any radius anyway.
        dx        = dx_full[10] ? '1 : dx_full[9:0];
        dy        = dy_full[10] ? '1 : dy_full[9:0];
        dx_sq     = {10'd0, dx} * {10'd0, dx};
        dy_sq     = {10'd0, dy} * {10'd0, dy};
        dist2     = {1'b0, dx_sq} + {1'b0, dy_sq};
        brick_hit = (cur_life != '0) && (dist2 <= R2);
        if (bx >= brk_l && bx <= brk_r) face_now = (by < brk_t) ? FACE_UP : FACE_DOWN;
        else                            face_now = (bx < brk_l) ? FACE_LEFT : FACE_RIGHT;
    end

    // Scan walker: brick index, column counter and cell origin; latches the first hit.
    always_ff @(posedge clock) begin
        if (hold || state == IDLE) begin
            idx       <= '0;
            col       <= '0;
            cell_x    <= X0_C;
            cell_y    <= Y0_C;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            hit_face  <= FACE_UP;
        end else if (state == SCAN) begin
            if (brick_hit && !hit_valid) begin
                hit_valid <= 1'b1;
                hit_idx   <= idx;
                hit_face  <= face_now;
            end
            idx <= idx + 5'd1;
            if (col == COL_LAST) begin
                col    <= '0;
                cell_x <= X0_C;
                cell_y <= cell_y + CELL_H;
            end else begin
                col    <= col + 5'd1;
                cell_x <= cell_x + CELL_W;
            end
        end
    end

    assign hit_block       = (state == REPORT) && hit_valid;
    assign hit_block_up    = hit_block && (hit_face == FACE_UP);
    assign hit_block_down  = hit_block && (hit_face == FACE_DOWN);
    assign hit_block_left  = hit_block && (hit_face == FACE_LEFT);
    assign hit_block_right = hit_block && (hit_face == FACE_RIGHT);
    assign hit_id          = hit_block ? hit_idx : 5'd0;
    assign destroyed       = hit_block && (hit_life == LIFE_W'(1));

    // Lives after this cycle's REPORT decrement, and whether any survive.
    always_comb begin
        any_live_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            life_next[i] = life[i];
            if (hit_block && hit_idx == 5'(i)) life_next[i] = life[i] - LIFE_W'(1);
            if (life_next[i] != '0) any_live_next = 1'b1;
        end
    end

    // Per-brick lives, restored whenever the field is held.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            // NOTE: lives are a few flops of game state, so they are reset; this is not a RAM.
            if (hold) life[i] <= INIT_LIVES[i*LIFE_W +: LIFE_W];
            else      life[i] <= life_next[i];
        end
    end

    // Cleared flag, registered from the post-decrement lives.
    always_ff @(posedge clock) begin
        if (hold) cleared <= 1'b0;
        else      cleared <= !any_live_next;
    end

    // Pixel decode: cell by shift, margin by mask, then live-brick lookup and colour.
    always_comb begin
        px      = {1'b0, next_x} - X0_C;
        py      = {1'b0, next_y} - Y0_C;
        in_grid = ({1'b0, next_x} >= X0_C) && (px < GRID_W) &&
                  ({1'b0, next_y} >= Y0_C) && (py < GRID_H);
        cx      = px >> XS;
        cy      = py >> YS;
        ox      = px & MASK_X;
        oy      = py & MASK_Y;
        in_body = (ox >= GAP_C) && (ox <= R_OFF_X) && (oy >= GAP_C) && (oy <= R_OFF_Y);
        pix_idx = 16'(cy) * 16'(COLS) + 16'(cx);
        pix_life = '0;
        for (int i = 0; i < N; i++) begin
            if (pix_idx == 16'(i)) pix_life = life[i];
        end
        area_d = in_grid && in_body && (pix_life != '0);
        rgb_d  = 24'd0;
        if (area_d) begin
            if (pix_life == LIFE_W'(1))      rgb_d = {8'd100, 8'd50, 8'd230};
            else if (pix_life == LIFE_W'(2)) rgb_d = {8'd10, 8'd230, 8'd50};
            else                             rgb_d = {8'd230, 8'd200, 8'd20};
        end
    end

    // Pixel output register: one cycle behind next_x/next_y.
    always_ff @(posedge clock) begin
        if (hold) begin
            area <= 1'b0;
            rgb  <= 24'd0;
        end else begin
            area <= area_d;
            rgb  <= rgb_d;
        end
    end

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: a geometric reference model is compared
// against every output on every cycle, plus hand-computed directed expectations.
module tb_brick_field;

    localparam int COLS = 5, ROWS = 2, BRICK_W = 128, BRICK_H = 32;
    localparam int X0 = 0, Y0 = 0, GAP = 2, R_BALL = 8, LIFE_W = 2;
    localparam int N = ROWS * COLS;
    localparam int MAXL = (1 << LIFE_W) - 1;
    localparam logic [23:0] C1 = {8'd100, 8'd50, 8'd230};
    localparam logic [23:0] C2 = {8'd10, 8'd230, 8'd50};
    localparam logic [23:0] C3 = {8'd230, 8'd200, 8'd20};

    logic        clock = 1'b0;
    logic        reset, start, tick;
    logic [9:0]  x_ball, y_ball, next_x, next_y;
    logic        area, hit_block, hit_block_up, hit_block_down, hit_block_left, hit_block_right;
    logic        destroyed, cleared;
    logic [23:0] rgb;
    logic [4:0]  hit_id;

    always #5 clock = ~clock;

    brick_field #(
        .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .X0(X0), .Y0(Y0),
        .GAP(GAP), .R_BALL(R_BALL), .LIFE_W(LIFE_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .x_ball(x_ball), .y_ball(y_ball), .next_x(next_x), .next_y(next_y),
        .area(area), .rgb(rgb), .hit_block(hit_block),
        .hit_block_up(hit_block_up), .hit_block_down(hit_block_down),
        .hit_block_left(hit_block_left), .hit_block_right(hit_block_right),
        .hit_id(hit_id), .destroyed(destroyed), .cleared(cleared)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_BUSY, M_REP} mstate_t;
    int          m_life [N];
    mstate_t     m_state = M_IDLE;
    int          m_left, m_rep_id;
    bit          m_rep_found;
    logic        checking = 1'b0;
    logic        exp_area = 0, exp_hit = 0, exp_destroyed = 0, exp_cleared = 0;
    logic [23:0] exp_rgb = 0;
    logic [3:0]  exp_face = 0;   // {up, down, left, right}
    logic [4:0]  exp_id = 0;

    function automatic int init_life(input int i);
        int v;
        v = ROWS - i / COLS;
        if (v > MAXL) v = MAXL;
`ifdef BRICK_FIELD_DURABILITY_EN
        return v;
`else
        return (v > 0) ? 1 : 0;
`endif
    endfunction

    function automatic logic [23:0] colour(input int life);
        if (life == 0) return 24'd0;
        if (life == 1) return C1;
        if (life == 2) return C2;
        return C3;
    endfunction

    // Lowest-index live brick whose clamped point lies within the ball radius.
    function automatic void find_hit(input int xb, input int yb, output bit found,
                                     output int id, output logic [3:0] face);
        int c, r, l, rr, t, b, qx, qy, d;
        found = 0; id = 0; face = 4'b0000;
        for (int i = 0; i < N; i++) begin
            if (!found && m_life[i] > 0) begin
                c  = i % COLS;
                r  = i / COLS;
                l  = X0 + c * BRICK_W + GAP;
                rr = X0 + (c + 1) * BRICK_W - 1 - GAP;
                t  = Y0 + r * BRICK_H + GAP;
                b  = Y0 + (r + 1) * BRICK_H - 1 - GAP;
                qx = (xb < l) ? l : ((xb > rr) ? rr : xb);
                qy = (yb < t) ? t : ((yb > b) ? b : yb);
                d  = (xb - qx) * (xb - qx) + (yb - qy) * (yb - qy);
                if (d <= R_BALL * R_BALL) begin
                    found = 1;
                    id    = i;
                    if (xb >= l && xb <= rr) face = (yb < t) ? 4'b1000 : 4'b0100;
                    else                     face = (xb < l) ? 4'b0010 : 4'b0001;
                end
            end
        end
    endfunction

    // Model advances on the same edges as the DUT; it reads only bench-driven inputs.
    always @(posedge clock) begin
        bit         found;
        int         id, nx, ny, idx, life, live;
        logic [3:0] face;
        if (reset || !start) begin
            for (int i = 0; i < N; i++) m_life[i] = init_life(i);
            m_state = M_IDLE;
            exp_area = 0; exp_rgb = 0; exp_hit = 0; exp_face = 0; exp_id = 0;
            exp_destroyed = 0; exp_cleared = 0;
        end else begin
            nx = int'(next_x) - X0;
            ny = int'(next_y) - Y0;
            exp_area = 0; exp_rgb = 0;
            if (nx >= 0 && ny >= 0 && nx < COLS * BRICK_W && ny < ROWS * BRICK_H &&
                nx % BRICK_W >= GAP && nx % BRICK_W <= BRICK_W - 1 - GAP &&
                ny % BRICK_H >= GAP && ny % BRICK_H <= BRICK_H - 1 - GAP) begin
                idx  = (ny / BRICK_H) * COLS + nx / BRICK_W;
                life = m_life[idx];
                exp_area = (life > 0);
                exp_rgb  = colour(life);
            end
            exp_hit = 0; exp_face = 0; exp_id = 0; exp_destroyed = 0;
            case (m_state)
                M_IDLE: if (tick) begin m_state = M_BUSY; m_left = N; end
                M_BUSY: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = M_REP;
                        find_hit(int'(x_ball), int'(y_ball), found, id, face);
                        m_rep_found = found;
                        m_rep_id    = id;
                        if (found) begin
                            exp_hit = 1; exp_face = face; exp_id = 5'(id);
                            exp_destroyed = (m_life[id] == 1);
                        end
                    end
                end
                default: begin
                    if (m_rep_found) m_life[m_rep_id]--;
                    m_state = M_IDLE;
                end
            endcase
            live = 0;
            for (int i = 0; i < N; i++) if (m_life[i] > 0) live++;
            exp_cleared = (live == 0);
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clock) begin
        if (checking) begin
            check("m_area", area, exp_area);
            check("m_rgb", rgb, exp_rgb);
            check("m_hit", hit_block, exp_hit);
            check("m_face", {hit_block_up, hit_block_down, hit_block_left, hit_block_right}, exp_face);
            check("m_id", hit_id, exp_id);
            check("m_destroyed", destroyed, exp_destroyed);
            check("m_cleared", cleared, exp_cleared);
        end
    end

    // ---------------- stimulus ----------------
    task automatic sync();
        @(posedge clock); #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clock); #1;
        tick = 1'b0;
    endtask

    task automatic set_ball(input int x, input int y);
        x_ball = 10'(x); y_ball = 10'(y);
    endtask

    task automatic set_pixel(input int x, input int y);
        next_x = 10'(x); next_y = 10'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] row0_colour;
`ifdef BRICK_FIELD_DURABILITY_EN
        row0_colour = C2;
`else
        row0_colour = C1;
`endif
        reset = 1'b1; start = 1'b0; tick = 1'b0;
        set_ball(320, 400);
        set_pixel(700, 400);
        repeat (2) @(posedge clock);
        #1;
        checking = 1'b1;
        @(negedge clock);
        check("reset_hit", hit_block, 1'b0);
        check("reset_area", area, 1'b0);
        sync();
        reset = 1'b0; start = 1'b1;

        // Idle field: pixel (64,16) is on brick 0.
        set_pixel(64, 16);
        @(posedge clock); @(negedge clock);
        check("pix_area", area, 1'b1);
        check("pix_rgb", rgb, row0_colour);
        check("pix_cleared", cleared, 1'b0);
        check("pix_hit", hit_block, 1'b0);

        // Ball (64,68) under brick 5: report in cycle t+11.
        sync();
        set_ball(64, 68);
        pulse_tick();
        repeat (N) @(posedge clock);
        @(negedge clock);
        check("b5_hit", hit_block, 1'b1);
        check("b5_down", hit_block_down, 1'b1);
        check("b5_id", hit_id, 5'd5);
        check("b5_destroyed", destroyed, 1'b1);
        @(posedge clock); #1;
        set_pixel(64, 48);
        @(posedge clock); @(negedge clock);
        check("b5_area_gone", area, 1'b0);

        // Ball (64,36) overlaps bricks 0 and 5 (5 already gone): brick 0 only.
        sync();
        set_ball(64, 36);
        pulse_tick();
        repeat (N) @(posedge clock);
        @(negedge clock);
        check("b0_hit", hit_block, 1'b1);
        check("b0_id", hit_id, 5'd0);
        check("b0_down", hit_block_down, 1'b1);
`ifdef BRICK_FIELD_DURABILITY_EN
        check("b0_destroyed", destroyed, 1'b0);
`else
        check("b0_destroyed", destroyed, 1'b1);
`endif
        @(posedge clock); #1;
        set_pixel(64, 16);
        @(posedge clock); @(negedge clock);
`ifdef BRICK_FIELD_DURABILITY_EN
        check("b0_area_after", area, 1'b1);
        check("b0_rgb_after", rgb, C1);
`else
        check("b0_area_after", area, 1'b0);
`endif
        sync();
        pulse_tick();
        repeat (N) @(posedge clock);
        @(negedge clock);
`ifdef BRICK_FIELD_DURABILITY_EN
        check("b0_second_hit", hit_block, 1'b1);
        check("b0_second_destroyed", destroyed, 1'b1);
`else
        check("b0_second_hit", hit_block, 1'b0);
`endif

        // Brick 2 with a repeated tick at t+3 that must be ignored.
        sync();
        set_ball(320, 16);
        pulse_tick();
        repeat (2) @(posedge clock);
        #1 tick = 1'b1;
        @(posedge clock);
        #1 tick = 1'b0;
        repeat (N - 3) @(posedge clock);
        @(negedge clock);
        check("b2_hit", hit_block, 1'b1);
        check("b2_id", hit_id, 5'd2);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("retick_ignored", hit_block, 1'b0);

        // Reset sampled at t+5 aborts the scan on brick 3.
        sync();
        set_ball(448, 16);
        pulse_tick();
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_hit", hit_block, 1'b0);
        check("abort_area", area, 1'b0);
        check("abort_rgb", rgb, 24'd0);
        check("abort_id", hit_id, 5'd0);
        check("abort_cleared", cleared, 1'b0);
        repeat (N + 2) @(posedge clock);

        // Strike every brick at its centre until the field is empty.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < init_life(i); k++) begin
                sync();
                set_ball(X0 + (i % COLS) * BRICK_W + BRICK_W / 2, Y0 + (i / COLS) * BRICK_H + BRICK_H / 2);
                pulse_tick();
                repeat (N) @(posedge clock);
                @(negedge clock);
                check("clr_hit", hit_block, 1'b1);
                check("clr_id", hit_id, 5'(i));
                check("clr_destroyed", destroyed, (k == init_life(i) - 1));
                if (i == N - 1 && k == init_life(i) - 1) begin
                    check("clr_not_yet", cleared, 1'b0);
                    @(posedge clock); @(negedge clock);
                    check("clr_cleared", cleared, 1'b1);
                end
            end
        end

        // One cycle of start low restores the field.
        sync();
        set_pixel(64, 16);
        start = 1'b0;
        @(posedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        check("restart_cleared", cleared, 1'b0);
        check("restart_area_held", area, 1'b0);
        @(posedge clock); @(negedge clock);
        check("restart_area", area, 1'b1);
        check("restart_rgb", rgb, row0_colour);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brick_field.md
# brick_field

Parametrised brick-wall manager for the Breakout design, replacing the fixed array of ten hand-instantiated `bloco` instances in the top level. It holds per-brick state for a ROWS×COLS grid and, once per ball step, scans the grid to resolve at most one ball/brick collision, reporting the struck face to `move_ball`. It also drives a 1-cycle-registered pixel colour for the VGA colour mux and flags when the field is cleared for `placar`.

## Interface
Parameters:
- `COLS`, 5: bricks per row
- `ROWS`, 2: brick rows; N = ROWS*COLS, max 32
- `BRICK_W`, 128: cell width in pixels, power of two
- `BRICK_H`, 32: cell height in pixels, power of two
- `X0`, 0: left edge of grid
- `Y0`, 0: top edge of grid
- `GAP`, 2: blank margin inside each cell edge
- `R_BALL`, 8: ball radius
- `LIFE_W`, 2: life counter width

Ports:
- `clock` in 1: VGA_CLK domain clock
- `reset` in 1: synchronous, active-high
- `start` in 1: level; while low the field is held at its initial state
- `tick` in 1: one-cycle pulse, once per ball position update
- `x_ball`, `y_ball` in 10: ball centre
- `next_x`, `next_y` in 10: pixel being drawn
- `area` out 1: registered; pixel lies on a live brick
- `rgb` out 24: registered {R,G,B} for that pixel; 0 when `area`=0
- `hit_block` out 1: one-cycle collision pulse
- `hit_block_up`, `hit_block_down`, `hit_block_left`, `hit_block_right` out 1: struck face; valid only with `hit_block`
- `hit_id` out 5: index of the struck brick; valid only with `hit_block`
- `destroyed` out 1: one-cycle pulse when a brick's life reaches 0
- `cleared` out 1: registered; all lives are 0

## Operation
- Brick i sits at col = i mod COLS and row = i / COLS.
- Its rectangle spans L = X0 + col*BRICK_W + GAP to R = X0 + (col+1)*BRICK_W − 1 − GAP, and T/B likewise in y.
- The RTL walks col/row counters during the scan. No dividers.
- Life init: life[i] = 1.
- Reset, or `start`=0: all lives re-initialised, FSM to IDLE, all outputs 0.
- FSM states:
  - IDLE: `tick` → SCAN with idx=0.
  - SCAN: one brick per cycle. A brick hits if life≠0 and the clamped-point distance test passes: dx = x_ball − clamp(x_ball, L, R), dy likewise, unsigned 21-bit dx²+dy² ≤ R_BALL². The first hit in the scan (lowest idx) is latched. After idx=N−1 → REPORT.
  - REPORT: if a hit was latched, pulse `hit_block`, the face flag and `hit_id`, and decrement that life. If the new life is 0, also pulse `destroyed`. Then → IDLE.
- Face rule:
  - x_ball in [L,R]: face is up if y_ball < T, else down.
  - Otherwise: face is left if x_ball < L, else right.
  - Exactly one face flag is set per hit.
- A `tick` received outside IDLE is ignored.
- Pixel path:
  - cx = (next_x − X0) >> log2(BRICK_W); cy likewise in y.
  - `area` = in grid, outside GAP, and life[cy*COLS+cx]≠0, registered once.
  - Colour by remaining life: 1 → (100,50,230), 2 → (10,230,50), ≥3 → (230,200,20).
- `cleared` is updated every cycle from an OR-reduce of all lives, registered.

## Timing
- `tick` at cycle t: SCAN runs cycles t+1 through t+N, and REPORT outputs are asserted in cycle t+N+1. Latency is fixed regardless of hit index.
- `destroyed` is coincident with `hit_block`.
- `cleared` rises one cycle after the final decrement.
- Pixel path latency is exactly 1 cycle (`area`/`rgb` lag `next_x`/`next_y` by one).
- The life update in REPORT is seen by the pixel path on the following cycle.
- Reset or `start` low mid-scan aborts the scan with no pulse. All outputs read 0 in the cycle after reset is sampled.
- At most one hit per `tick`, even if the ball overlaps several bricks.

## Configuration
- `BRICK_FIELD_DURABILITY_EN` defined: life[i] initialises to min(ROWS − row, 2^LIFE_W − 1), so upper rows take more hits.
- Undefined: every brick has life 1, and `destroyed` equals `hit_block`.

## Test plan
- Reset, `start`=1, no tick → `area`=1 at pixel (64,16) one cycle later, `rgb`=per-row colour; `cleared`=0, `hit_block`=0.
- Ball (64,68), `tick` at t → at t+11: `hit_block`=1, `hit_block_down`=1, `hit_id`=5, `destroyed`=1; pixel (64,48) then `area`=0.
- Ball (64,36), overlapping bricks 0 and 5, `tick` → only `hit_id`=0 reported (lowest index).
- With `BRICK_FIELD_DURABILITY_EN`: two hits on brick 0 → first gives `destroyed`=0 and colour becomes (100,50,230), second gives `destroyed`=1.
- Hit all 10 bricks (durability off) → `cleared`=1 one cycle after the 10th REPORT. Then `start`=0 for one cycle → all bricks restored and `cleared`=0.
- `tick` repeated at t+3 mid-scan, and separately `reset` at t+5 → the repeated tick is ignored; the reset produces no pulse and all outputs are 0 at t+6.
